// File: rtl/system_key_in.sv
// -----------------------------------------------------------------------------
// system_key_in
//
// Avalon-MM slave input port for the DE-series push-buttons and switches.
// Each external pin is brought into the clk domain through a two-flop
// synchroniser, debounced by a per-bit stability counter, and watched for
// edges. Detected edges latch into a write-1-to-clear capture register that,
// gated by an interrupt mask, drives a level interrupt to the Nios II.
//
// Ports
//   clk         system clock, the only clock
//   reset_n     synchronous, active-low reset
//   address     register select (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect  slave select, qualifies write_n
//   write_n     active-low write strobe
//   writedata   write data; bits at WIDTH and above are ignored
//   in_port     asynchronous external pins
//   readdata    registered read data, latency 1, no read side effects
//   irq         level interrupt, |(edgecapture & irqmask)
//
// Parameters
//   WIDTH            number of pins (1..32)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a new level
//   CNT_W            width of each debounce counter
//   EDGE_TYPE        0 rising, 1 falling, 2 any
//   IDLE_LEVEL       reset level of synchroniser and debounced state
// -----------------------------------------------------------------------------
module system_key_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_RSVD  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic             write_en;
  logic             wr_mask;
  logic             wr_clear;
  logic [WIDTH-1:0] clear_bits;

  assign write_en   = chipselect & ~write_n;
  assign wr_mask    = write_en && (address == ADDR_MASK);
  assign wr_clear   = write_en && (address == ADDR_EDGE);
  assign clear_bits = wr_clear ? writedata[WIDTH-1:0] : '0;

  // Upper writedata bits carry no meaning for narrow ports.
  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_writedata_hi;
      assign unused_writedata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Synchroniser: two flops per pin to settle metastability.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= IDLE_VEC;
      sync2 <= IDLE_VEC;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, forming
      // a real two-stage chain; blocking here would collapse it to one flop.
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: a bit accepts the synchronised level only after it has differed
  // from the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
  // Any return to the debounced level restarts the count, so short glitches
  // never propagate.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      debounced <= IDLE_VEC;
      // NOTE: the counter array is explicitly cleared because a partial count
      // surviving reset could accept a level early; it is small flop state,
      // not a RAM, so resetting it costs nothing structurally.
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == debounced[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          debounced[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detect on the debounced level.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;

  assign rise = debounced & ~debounced_d;
  assign fall = ~debounced & debounced_d;

  always_comb begin
    // NOTE: default assignment first so every path drives edge_det and no
    // latch is inferred.
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  // debounced_d resets to the same idle level as debounced, so the first
  // cycle after reset never sees an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      debounced_d <= IDLE_VEC;
    end else begin
      debounced_d <= debounced;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture and mask registers. A set coinciding with a W1C clear wins so an
  // edge arriving during the ISR's acknowledge is not lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      edgecapture <= (edgecapture & ~clear_bits) | edge_det;
      if (wr_mask) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(edgecapture & irqmask);

  // ---------------------------------------------------------------------------
  // Read path: the mux is registered every cycle regardless of chipselect,
  // giving a fixed read latency of one clock. Values are taken before this
  // edge's updates, so a capture read in its set cycle returns the old value.
  // ---------------------------------------------------------------------------
  logic [31:0] read_mux;

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA: read_mux[WIDTH-1:0] = debounced;
      ADDR_RSVD: read_mux            = '0;
      ADDR_MASK: read_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGE: read_mux[WIDTH-1:0] = edgecapture;
      default:   read_mux            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_system_key_in.sv
// -----------------------------------------------------------------------------
// tb_system_key_in
//
// Directed bench for system_key_in with WIDTH=4, DEBOUNCE_CYCLES=4. dut1 uses
// falling-edge capture, dut2 any-edge capture; both share clock, reset and bus
// but have separate pins. Inputs change 1 ns after a rising edge and outputs
// are sampled at that same point, i.e. after the edge they depend on.
// -----------------------------------------------------------------------------
module tb_system_key_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  pins1;
  logic [3:0]  pins2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        irq1;
  logic        irq2;

  int checks   = 0;
  int failures = 0;

  system_key_in #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(16), .EDGE_TYPE(1), .IDLE_LEVEL(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pins1),
    .readdata(rd1), .irq(irq1)
  );

  system_key_in #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(16), .EDGE_TYPE(2), .IDLE_LEVEL(1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pins2),
    .readdata(rd2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;        // cycles to hold this vector; checked after the last
    logic [1:0]  addr;
    logic        cs;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  pins;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, logic [1:0] a, logic cs, logic wr,
                              logic [31:0] wd, logic [3:0] p,
                              logic [31:0] er, logic ei);
    vec_t v;
    v.n = n; v.addr = a; v.cs = cs; v.wr = wr; v.wdata = wd;
    v.pins = p; v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // One clock of bus activity on dut1's pins; returns 1 ns after the edge.
  task automatic drive(input logic [1:0] a, input logic cs, input logic wr,
                       input logic [31:0] wd, input logic [3:0] p);
    address    = a;
    chipselect = cs;
    write_n    = ~wr;
    writedata  = wd;
    pins1      = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    pins1      = 4'hF;
    pins2      = 4'hF;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_irq1", {31'b0, irq1}, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_irq2", {31'b0, irq2}, 32'h0);
    reset_n = 1'b1;

    // ---------------- table-driven main sequence (dut1) ----------------
    //                 n  ad cs wr  wdata          pins   exp_rd        irq
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         4'hF, 32'h0000000F, 0)); // idle data
    tbl.push_back(mk(1, 3, 0, 0, 32'h0,         4'hF, 32'h00000000, 0)); // no capture
    tbl.push_back(mk(5, 0, 0, 0, 32'h0,         4'hE, 32'h0000000F, 0)); // press key0
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         4'hE, 32'h0000000F, 0)); // 6th edge: update
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         4'hE, 32'h0000000E, 0)); // capture set
    tbl.push_back(mk(1, 3, 0, 0, 32'h0,         4'hE, 32'h00000001, 0)); // masked
    tbl.push_back(mk(1, 3, 1, 1, 32'h1,         4'hE, 32'h00000001, 0)); // W1C
    tbl.push_back(mk(1, 2, 1, 1, 32'h1,         4'hE, 32'h00000000, 0)); // mask=1
    tbl.push_back(mk(1, 2, 0, 0, 32'h0,         4'hE, 32'h00000001, 0));
    tbl.push_back(mk(3, 0, 0, 0, 32'h0,         4'hC, 32'h0000000E, 0)); // 3-cycle glitch key1
    tbl.push_back(mk(5, 0, 0, 0, 32'h0,         4'hE, 32'h0000000E, 0)); // glitch rejected
    tbl.push_back(mk(1, 3, 0, 0, 32'h0,         4'hE, 32'h00000000, 0));
    tbl.push_back(mk(5, 0, 0, 0, 32'h0,         4'hF, 32'h0000000E, 0)); // release key0
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         4'hF, 32'h0000000E, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         4'hF, 32'h0000000F, 0));
    tbl.push_back(mk(1, 3, 0, 0, 32'h0,         4'hF, 32'h00000000, 0)); // rise not captured
    tbl.push_back(mk(6, 0, 0, 0, 32'h0,         4'hE, 32'h0000000F, 0)); // press again
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         4'hE, 32'h0000000E, 1)); // irq in set cycle
    tbl.push_back(mk(1, 3, 0, 0, 32'h0,         4'hE, 32'h00000001, 1));
    tbl.push_back(mk(1, 3, 1, 1, 32'h1,         4'hE, 32'h00000001, 0)); // W1C drops irq
    tbl.push_back(mk(1, 3, 0, 0, 32'h0,         4'hE, 32'h00000000, 0));
    tbl.push_back(mk(8, 0, 0, 0, 32'h0,         4'hF, 32'h0000000F, 0)); // release
    tbl.push_back(mk(5, 0, 0, 0, 32'h0,         4'hE, 32'h0000000F, 0)); // press
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         4'hE, 32'h0000000F, 0));
    tbl.push_back(mk(1, 3, 1, 1, 32'h1,         4'hE, 32'h00000000, 1)); // set vs clear
    tbl.push_back(mk(1, 3, 0, 0, 32'h0,         4'hE, 32'h00000001, 1)); // set won
    tbl.push_back(mk(1, 3, 1, 1, 32'h1,         4'hE, 32'h00000001, 0));
    tbl.push_back(mk(1, 3, 0, 0, 32'h0,         4'hE, 32'h00000000, 0));
    tbl.push_back(mk(1, 2, 1, 1, 32'hFFFFFFF0,  4'hE, 32'h00000001, 0)); // high bits ignored
    tbl.push_back(mk(1, 2, 0, 0, 32'h0,         4'hE, 32'h00000000, 0));
    tbl.push_back(mk(1, 1, 1, 1, 32'hFFFFFFFF,  4'hE, 32'h00000000, 0)); // addr1 ignored
    tbl.push_back(mk(1, 2, 0, 1, 32'h0000000F,  4'hE, 32'h00000000, 0)); // cs low: no write
    tbl.push_back(mk(1, 2, 0, 0, 32'h0,         4'hE, 32'h00000000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,         4'hE, 32'h0000000E, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        drive(tbl[i].addr, tbl[i].cs, tbl[i].wr, tbl[i].wdata, tbl[i].pins);
      end
      check($sformatf("vec%0d_rd", i), rd1, tbl[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq1}, {31'b0, tbl[i].exp_irq});
    end

    // ---------------- reset midway through a debounce window ----------------
    repeat (8) drive(2'd0, 1'b0, 1'b0, 32'h0, 4'hF);
    check("pre_reset_idle", rd1, 32'h0000000F);
    repeat (4) drive(2'd0, 1'b0, 1'b0, 32'h0, 4'hE);   // counter part way
    reset_n = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 32'h0, 4'hE);
    check("midreset_rd", rd1, 32'h0);
    check("midreset_irq", {31'b0, irq1}, 32'h0);
    reset_n = 1'b1;
    // Full window must restart: debounced stays idle through the 6th edge.
    for (int r = 1; r <= 6; r++) begin
      drive(2'd0, 1'b0, 1'b0, 32'h0, 4'hE);
      check($sformatf("postreset_r%0d", r), rd1, 32'h0000000F);
    end
    drive(2'd0, 1'b0, 1'b0, 32'h0, 4'hE);
    check("postreset_update", rd1, 32'h0000000E);
    drive(2'd3, 1'b0, 1'b0, 32'h0, 4'hE);
    check("postreset_capture", rd1, 32'h00000001);
    check("postreset_irq", {31'b0, irq1}, 32'h0);

    // ---------------- any-edge capture on dut2, key2 ----------------
    check("dut2_clean", rd2, 32'h0);
    pins2 = 4'hB;
    repeat (8) drive(2'd3, 1'b0, 1'b0, 32'h0, 4'hE);
    check("dut2_press_cap", rd2, 32'h00000004);
    check("dut2_press_irq", {31'b0, irq2}, 32'h0);
    drive(2'd3, 1'b1, 1'b1, 32'h4, 4'hE);
    drive(2'd3, 1'b0, 1'b0, 32'h0, 4'hE);
    check("dut2_cleared", rd2, 32'h0);
    pins2 = 4'hF;
    repeat (8) drive(2'd3, 1'b0, 1'b0, 32'h0, 4'hE);
    check("dut2_release_cap", rd2, 32'h00000004);
    drive(2'd2, 1'b1, 1'b1, 32'h4, 4'hE);
    check("dut2_irq_unmasked", {31'b0, irq2}, 32'h1);
    drive(2'd3, 1'b1, 1'b1, 32'h4, 4'hE);
    check("dut2_irq_cleared", {31'b0, irq2}, 32'h0);
    drive(2'd0, 1'b0, 1'b0, 32'h0, 4'hE);
    check("dut2_data_idle", rd2, 32'h0000000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
